// File: rtl/rv32_mmio_timer.sv
// Memory-mapped prescaled timer with compare match, auto-reload and a level interrupt.
// Optional IRQEN/irq support is compiled in with `define RV32_MMIO_TIMER_IRQ_EN.
module rv32_mmio_timer #(
  parameter int              AW   = 32,
  parameter int              DW   = 32,
  parameter logic [AW-1:0]   BASE = 'h2000
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] address,
  input  logic          read,
  input  logic          write,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          irq
);

  localparam logic [2:0] R_CTRL   = 3'd0;
  localparam logic [2:0] R_PRESC  = 3'd1;
  localparam logic [2:0] R_COUNT  = 3'd2;
  localparam logic [2:0] R_CMP    = 3'd3;
  localparam logic [2:0] R_STATUS = 3'd4;

  typedef struct packed {
    logic ie;
    logic ar;
    logic en;
  } ctrl_t;

  ctrl_t       ctrl;
  logic [15:0] prescale;
  logic [15:0] pcnt;
  logic [31:0] count;
  logic [31:0] compare;
  logic        pend;

  logic        hit;
  logic [2:0]  idx;
  logic        wr_ctrl, wr_presc, wr_count, wr_cmp, wr_status;
  logic        tick, match;
  logic        pend_nxt, ie_nxt;
  logic        unused_addr;

  // Sub-word offsets are ignored: every access is treated as a full word.
  assign unused_addr = ^address[1:0];

  assign hit       = address[AW-1:5] == BASE[AW-1:5];
  assign idx       = address[4:2];
  assign wr_ctrl   = write && hit && (idx == R_CTRL);
  assign wr_presc  = write && hit && (idx == R_PRESC);
  assign wr_count  = write && hit && (idx == R_COUNT);
  assign wr_cmp    = write && hit && (idx == R_CMP);
  assign wr_status = write && hit && (idx == R_STATUS);

  assign tick  = ctrl.en && (pcnt == prescale);
  // A software COUNT write in a tick cycle suppresses that cycle's compare.
  assign match = tick && !wr_count && (count == compare);

  // Set beats write-1-clear when both land on the same edge.
  assign pend_nxt = match || (pend && !(wr_status && wdata[0]));

`ifdef RV32_MMIO_TIMER_IRQ_EN
  assign ie_nxt = wr_ctrl ? wdata[2] : ctrl.ie;
`else
  assign ie_nxt = 1'b0;
`endif

  always_comb begin
    rdata = '0;
    if (read && hit) begin
      case (idx)
        R_CTRL:   rdata = {{(DW-3){1'b0}}, ctrl};
        R_PRESC:  rdata = {{(DW-16){1'b0}}, prescale};
        R_COUNT:  rdata = count;
        R_CMP:    rdata = compare;
        R_STATUS: rdata = {{(DW-1){1'b0}}, pend};
        default:  rdata = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ctrl     <= '0;
      prescale <= '0;
      pcnt     <= '0;
      count    <= '0;
      compare  <= '0;
      pend     <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr_ctrl)
        ctrl <= '{ie: ie_nxt, ar: wdata[1], en: wdata[0]};
      if (wr_presc)
        prescale <= wdata[15:0];
      if (wr_cmp)
        compare <= wdata;

      // Reprogramming the rate or enable restarts the prescaler phase.
      if (wr_ctrl || wr_presc)
        pcnt <= '0;
      else if (ctrl.en)
        pcnt <= tick ? 16'd0 : pcnt + 16'd1;

      if (wr_count)
        count <= wdata;
      else if (tick)
        count <= (match && ctrl.ar) ? 32'd0 : count + 32'd1;

      pend <= pend_nxt;
      irq  <= pend_nxt && ie_nxt;
    end
  end

endmodule
